// File: rtl/fft_pkg.sv
// fft_pkg: shared state encoding and default widths for the radix-6 pipeline delay stages
package fft_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;
  localparam int W_DEF     = 8;
  localparam int RADIX_DEF = 6;
  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_FILL  = ST_FILL,
    S_RUN   = ST_RUN,
    S_DRAIN = ST_DRAIN
  } state_t;
endpackage

// File: rtl/dly_ram.sv
// dly_ram: DEPTH x W dual-port RAM, synchronous write, asynchronous read
//   clk          write clock
//   we/waddr/wdata  write port
//   raddr/rdata  combinational read port (returns contents before a same-cycle write)
module dly_ram #(
  parameter int W = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/delay_fb_reader.sv
// delay_fb_reader: valid-gated circular delay of DEPTH accepted samples with drain-on-flush
//   clk, rst_n   clock, asynchronous active-low reset
//   a, b         input sample and valid
//   flush        one-cycle request to drain the buffered samples
//   a1, b1       delayed sample and valid (registered)
//   phase        butterfly branch index 0..RADIX-1, advances with every b1
//   busy         high while draining
//   occ          buffer occupancy, present only when DELAY_FB_OCC_EN is defined
module delay_fb_reader import fft_pkg::*; #(
  parameter int W = W_DEF,
  parameter int DEPTH = 8,
  parameter int RADIX = RADIX_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [W-1:0]           a,
  input  logic                   b,
  input  logic                   flush,
  output logic [W-1:0]           a1,
  output logic                   b1,
  output logic [2:0]             phase,
  output logic                   busy
`ifdef DELAY_FB_OCC_EN
  , output logic [$clog2(DEPTH):0] occ
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  state_t st;
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [W-1:0] rd;
  logic we;
  logic [2:0] phase_inc;
  assign we = b && st != S_DRAIN;
  assign phase_inc = phase == 3'(RADIX-1) ? 3'd0 : phase + 3'd1;
`ifdef DELAY_FB_OCC_EN
  assign occ = cnt;
`endif
  dly_ram #(.W(W), .DEPTH(DEPTH)) u_ram (
    .clk(clk), .we(we), .waddr(wp), .wdata(a), .raddr(rp), .rdata(rd)
  );
  // In RUN the read of rp sees the old contents while wp==rp is overwritten at the same edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= S_IDLE;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      a1 <= '0;
      b1 <= 1'b0;
      phase <= 3'd0;
      busy <= 1'b0;
    end else if (st == S_DRAIN) begin
      if (cnt != '0) begin
        a1 <= rd;
        rp <= rp + 1'b1;
        cnt <= cnt - 1'b1;
        b1 <= 1'b1;
        phase <= phase_inc;
      end else begin
        st <= S_IDLE;
        busy <= 1'b0;
        phase <= 3'd0;
        wp <= rp;
        b1 <= 1'b0;
      end
    end else begin
      b1 <= b && st == S_RUN;
      if (b) begin
        wp <= wp + 1'b1;
        if (st == S_RUN) begin
          a1 <= rd;
          rp <= rp + 1'b1;
          phase <= phase_inc;
        end else begin
          cnt <= cnt + 1'b1;
          st <= cnt == FULL - 1'b1 ? S_RUN : S_FILL;
        end
      end
      if (flush && st != S_IDLE) begin
        st <= S_DRAIN;
        busy <= 1'b1;
      end
    end
endmodule

// File: tb/tb_delay_fb_reader.sv
// tb_delay_fb_reader: scoreboard bench for delay_fb_reader (DEPTH=8, RADIX=6)
module tb_delay_fb_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] a = '0;
  logic b = 1'b0;
  logic flush = 1'b0;
  logic [7:0] a1;
  logic b1;
  logic [2:0] phase;
  logic busy;
`ifdef DELAY_FB_OCC_EN
  logic [3:0] occ;
`endif
  always #5 clk = ~clk;
  delay_fb_reader dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .flush(flush),
    .a1(a1), .b1(b1), .phase(phase), .busy(busy)
`ifdef DELAY_FB_OCC_EN
    , .occ(occ)
`endif
  );
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  logic [7:0] ea1;
  bit mdrain;
  bit mbusy;
  int mphase;
  task automatic check(input string tag, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    exp_q.delete();
    ea1 = '0;
    mdrain = 0;
    mbusy = 0;
    mphase = 0;
  endtask
  task automatic check_state();
    check("phase", phase, mphase);
    check("busy", busy, mbusy);
`ifdef DELAY_FB_OCC_EN
    check("occ", occ, q.size());
`endif
  endtask
  task automatic step(input logic [7:0] va, input logic vb, input logic vf);
    logic [7:0] o;
    bit eb1;
    bit act;
    eb1 = 0;
    act = q.size() > 0;
    a = va;
    b = vb;
    flush = vf;
    if (mdrain) begin
      if (q.size() > 0) begin
        o = q.pop_front();
        exp_q.push_back(o);
        eb1 = 1;
      end else begin
        mdrain = 0;
        mbusy = 0;
        mphase = 0;
      end
    end else begin
      if (vb) begin
        q.push_back(va);
        if (q.size() > 8) begin
          o = q.pop_front();
          exp_q.push_back(o);
          eb1 = 1;
        end
      end
      if (vf && act) begin
        mdrain = 1;
        mbusy = 1;
      end
    end
    if (eb1) mphase = (mphase + 1) % 6;
    @(posedge clk);
    #1;
    check("b1", b1, eb1);
    if (b1) begin
      check("sb_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        o = exp_q.pop_front();
        ea1 = o;
        check("a1", a1, o);
      end
    end else check("a1_hold", a1, ea1);
    check_state();
  endtask
  task automatic drain_idle();
    repeat (12) step(8'h00, 1'b0, 1'b0);
  endtask
  task automatic stream(input int first, input int n);
    for (int i = 0; i < n; i++) step(8'(first + i), 1'b1, 1'b0);
  endtask
  initial begin
    int v;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_a1", a1, 0);
    check("rst_b1", b1, 0);
    check_state();
    rst_n = 1'b1;
    stream(1, 30);
    step(8'h00, 1'b0, 1'b1);
    drain_idle();
    v = 1;
    for (int i = 0; i < 45; i++)
      if (i % 3 == 2) step(8'hee, 1'b0, 1'b0);
      else begin
        step(8'(v), 1'b1, 1'b0);
        v++;
      end
    step(8'h00, 1'b0, 1'b1);
    drain_idle();
    stream(10, 5);
    step(8'h00, 1'b0, 1'b1);
    repeat (5) step(8'd99, 1'b1, 1'b0);
    drain_idle();
    stream(30, 20);
    step(8'd50, 1'b1, 1'b1);
    drain_idle();
    stream(1, 4);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_a1", a1, 0);
    check("arst_b1", b1, 0);
    check_state();
    #2;
    rst_n = 1'b1;
    stream(1, 30);
    step(8'h00, 1'b0, 1'b1);
    drain_idle();
    check("sb_leftover", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/delay_fb_reader.md
Name: delay_fb_reader

Overview:
- Valid-gated circular delay buffer for the radix-6 pipeline stages. It consumes the data/valid stream from the upstream fixed shift-register delay and re-emits each sample exactly DEPTH accepted samples later.
- Unlike the fixed delay, it advances only on valid input, so gaps in the stream do not corrupt alignment.
- Drives a branch-phase count for the downstream butterfly.
- Supports an explicit flush that drains residual samples at end of frame.

Parameters:
- W, 8, data width
- DEPTH, 8, delay in accepted samples (power of two, ≥2)
- RADIX, 6, modulus of output phase counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- a  in  W  input sample
- b  in  1  input valid
- flush  in  1  single-cycle request to drain the buffer
- a1  out  W  delayed sample (registered)
- b1  out  1  output valid (registered)
- phase  out  3  output branch index 0..RADIX-1
- busy  out  1  high while in DRAIN

Behaviour:
- One clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - a1=0, b1=0, phase=0, busy=0
  - state=IDLE
  - write ptr wp=0, read ptr rp=0, occupancy cnt=0
  - RAM contents are not reset.
- Storage: DEPTH×W circular RAM. Pointers wrap DEPTH-1→0. cnt is $clog2(DEPTH)+1 bits.
- States:
  - IDLE: cnt=0
  - FILL: 0<cnt<DEPTH
  - RUN: cnt=DEPTH
  - DRAIN
- IDLE/FILL, b=1:
  - mem[wp]<=a, wp++, cnt++, b1<=0.
  - IDLE→FILL on the first accept. FILL→RUN when cnt reaches DEPTH.
- RUN, b=1:
  - a1<=mem[rp] (old value, read-before-write), mem[wp]<=a, wp++, rp++, b1<=1, phase++ mod RADIX.
  - cnt unchanged.
- Any state other than DRAIN, b=0: no pointer change, b1<=0, a1 holds.
- Latency: a sample accepted on valid cycle k appears on a1 with b1=1 one clock after the DEPTH-th later accepted valid.
- flush:
  - Ignored in IDLE and in DRAIN.
  - In FILL or RUN, a same-cycle b=1 sample is first processed normally, then state→DRAIN and busy<=1.
- DRAIN:
  - Each cycle with cnt>0: a1<=mem[rp], rp++, cnt--, b1<=1, phase++ mod RADIX. Input b is ignored and the sample is dropped.
  - When cnt reaches 0 (after the last output): state→IDLE, busy<=0, phase<=0, wp<=rp.
- phase increments only on cycles where b1 is driven 1. It wraps RADIX-1→0.
- Reset asserted mid-operation (any state) returns immediately to reset values. Buffered samples are discarded.

Optional Feature:
- Macro DELAY_FB_OCC_EN.
- Defined: adds output port occ [$clog2(DEPTH):0], equal to registered cnt (0 at reset), for debug and monitoring.
- Undefined: port absent. cnt stays internal with no other behavioural change.

Decomposition:
- Shared package fft_pkg holds:
  - state encoding localparams: ST_IDLE=0, ST_FILL=1, ST_RUN=2, ST_DRAIN=3
  - default W=8 and RADIX=6 constants
- One natural sub-module: dly_ram, a simple dual-port DEPTH×W synchronous-write / asynchronous-read RAM. The top holds the FSM, pointers and output registers.

Test Plan (DEPTH=8, RADIX=6):
- Reset, then b=1 with a=1,2,3,… contiguous → b1=0 for the first 8 accepts; a1=1, b1=1 on the clock after a=9 is presented; then a1=2,3,… each cycle; phase sequence 0→1→…→5→0.
- Same stream with b=0 inserted every third cycle → outputs remain in order 1,2,3,… with no skips or repeats; b1=0 and a1 held on gap cycles; phase advances only on b1=1.
- Load 5 samples (10..14), pulse flush → busy=1; a1=10..14 on 5 consecutive cycles with b1=1; then busy=0 and state IDLE; b=1 with a=99 during the drain is ignored.
- In RUN, flush together with b=1, a=50 → 50 is accepted, 8 drain outputs follow ending with 50, then IDLE.
- Deassert rst_n mid-FILL (cnt=4) → a1=0, b1=0, phase=0, busy=0 immediately. A subsequent fresh stream behaves exactly as in the first scenario.
- With DELAY_FB_OCC_EN defined → occ tracks 0..8 during fill, holds 8 in RUN, and counts down to 0 in DRAIN.
